button_debounce: RTL

- Input conditioning stage for the icestick button-driven FSMs.
- Synchronises a raw active-low pushbutton to clk and rejects contact bounce.
- Emits a clean active-high level plus single-cycle press, release and long-press pulses.
- press_pulse drives the go input of the downstream counting state machine directly, in place of a raw button.

---
 rtl/button_debounce.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
//   Conditions a raw active-low pushbutton for the button-driven FSMs.
//   The button is synchronised to clk, contact bounce is rejected, and the
//   block emits a clean pressed level plus one-cycle press, release and
//   long-press pulses. press_pulse can drive a downstream "go" input directly.
//
// Ports:
//   clk           in   system clock (12 MHz)
//   rst_btn       in   asynchronous active-low reset
//   btn_in        in   raw pushbutton, 0 = pressed, asynchronous to clk
//   btn_level     out  debounced state, 1 = pressed
//   press_pulse   out  one-cycle pulse on an accepted press
//   release_pulse out  one-cycle pulse on an accepted release
//   long_press    out  one-cycle pulse after a long hold, once per press
// ----------------------------------------------------------------------------
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES   = 120000,
  parameter int unsigned LONG_PRESS_CYCLES = 12000000,
  parameter int unsigned CNT_WIDTH         = 24
) (
  input  logic clk,
  input  logic rst_btn,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam logic [CNT_WIDTH-1:0] DEB_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] HOLD_MAX = CNT_WIDTH'(LONG_PRESS_CYCLES);
  localparam logic [CNT_WIDTH-1:0] HOLD_PRE = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_sync_in;
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_deb_cnt;
  logic [CNT_WIDTH-1:0] r_hold_cnt;

  // Two-flop synchroniser; resets to the released level (1).
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  // Invert so that 1 means pressed from here on.
  assign w_sync_in = ~r_sync2;

  // Debounce / hold-timer state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      r_state       <= IDLE;
      r_deb_cnt     <= CNT_ZERO;
      r_hold_cnt    <= CNT_ZERO;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_sync_in) begin
            r_state   <= PRESS_WAIT;
            r_deb_cnt <= CNT_ONE;
          end
        end

        PRESS_WAIT: begin
          if (!w_sync_in) begin
            r_state   <= IDLE;
            r_deb_cnt <= CNT_ZERO;
          end else if (r_deb_cnt == DEB_MAX) begin
            r_state     <= PRESSED;
            r_deb_cnt   <= CNT_ZERO;
            r_hold_cnt  <= CNT_ZERO;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            r_deb_cnt <= r_deb_cnt + CNT_ONE;
          end
        end

        PRESSED: begin
          // Saturating hold timer; the pulse fires only on the final step,
          // so a saturated counter never re-fires within one press.
          if (r_hold_cnt != HOLD_MAX) begin
            r_hold_cnt <= r_hold_cnt + CNT_ONE;
            if (r_hold_cnt == HOLD_PRE) begin
              long_press <= 1'b1;
            end
          end
          if (!w_sync_in) begin
            r_state   <= RELEASE_WAIT;
            r_deb_cnt <= CNT_ONE;
          end
        end

        RELEASE_WAIT: begin
          // Hold timer is frozen while a release is being qualified.
          if (w_sync_in) begin
            r_state   <= PRESSED;
            r_deb_cnt <= CNT_ZERO;
          end else if (r_deb_cnt == DEB_MAX) begin
            r_state       <= IDLE;
            r_deb_cnt     <= CNT_ZERO;
            r_hold_cnt    <= CNT_ZERO;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            r_deb_cnt <= r_deb_cnt + CNT_ONE;
          end
        end

        default: begin
          r_state   <= IDLE;
          r_deb_cnt <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule
